// File: rtl/id_ex_pipe_reg.sv
// ID/EX boundary register: latches decoded control, operands and register numbers for one EX cycle.
// 1-cycle latency; flush beats freeze beats hazard, and flush/hazard load an all-zero bubble.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  freezeIn,
  input  logic                  flushIn,
  input  logic                  hazardIn,
  input  logic                  forwardEnIn,
  input  logic [DATA_W-1:0]     pcIn,
  input  logic [DATA_W-1:0]     val1In,
  input  logic [DATA_W-1:0]     valRmIn,
  input  logic [3:0]            exeCmdIn,
  input  logic                  memREnIn,
  input  logic                  memWEnIn,
  input  logic                  wbEnIn,
  input  logic                  bIn,
  input  logic                  sIn,
  input  logic                  immIn,
  input  logic [11:0]           shiftOperandIn,
  input  logic [23:0]           signedImm24In,
  input  logic [REG_ADDR_W-1:0] destIn,
  input  logic [REG_ADDR_W-1:0] src1In,
  input  logic [REG_ADDR_W-1:0] src2In,
  input  logic                  carryIn,
  output logic [DATA_W-1:0]     pcOut,
  output logic [DATA_W-1:0]     val1Out,
  output logic [DATA_W-1:0]     valRmOut,
  output logic [3:0]            exeCmdOut,
  output logic                  memREnOut,
  output logic                  memWEnOut,
  output logic                  wbEnOut,
  output logic                  bOut,
  output logic                  sOut,
  output logic                  immOut,
  output logic [11:0]           shiftOperandOut,
  output logic [23:0]           signedImm24Out,
  output logic [REG_ADDR_W-1:0] destOut,
  output logic [REG_ADDR_W-1:0] src1Out,
  output logic [REG_ADDR_W-1:0] src2Out,
  output logic                  carryOut,
  output logic                  forwardEnOut,
  output logic                  validOut
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val_rm;
    logic [3:0]            exe_cmd;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;
    logic                  b;
    logic                  s;
    logic                  imm;
    logic [11:0]           shift_operand;
    logic [23:0]           signed_imm24;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic                  carry;
    logic                  forward_en;
    logic                  valid;
  } stage_t;

  stage_t stage_d, stage_q;

  // A bubble is all-zero, so it can never drive forwarding selects or write back.
  always_comb begin
    stage_d = stage_q;
    if (flushIn) begin
      stage_d = '0;
    end else if (!freezeIn) begin
      if (hazardIn) begin
        stage_d = '0;
      end else begin
        stage_d.pc            = pcIn;
        stage_d.val1          = val1In;
        stage_d.val_rm        = valRmIn;
        stage_d.exe_cmd       = exeCmdIn;
        stage_d.mem_r_en      = memREnIn;
        stage_d.mem_w_en      = memWEnIn;
        stage_d.wb_en         = wbEnIn;
        stage_d.b             = bIn;
        stage_d.s             = sIn;
        stage_d.imm           = immIn;
        stage_d.shift_operand = shiftOperandIn;
        stage_d.signed_imm24  = signedImm24In;
        stage_d.dest          = destIn;
        stage_d.src1          = src1In;
        stage_d.src2          = src2In;
        stage_d.carry         = carryIn;
        stage_d.forward_en    = forwardEnIn;
        stage_d.valid         = 1'b1;
      end
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign pcOut           = stage_q.pc;
  assign val1Out         = stage_q.val1;
  assign valRmOut        = stage_q.val_rm;
  assign exeCmdOut       = stage_q.exe_cmd;
  assign memREnOut       = stage_q.mem_r_en;
  assign memWEnOut       = stage_q.mem_w_en;
  assign wbEnOut         = stage_q.wb_en;
  assign bOut            = stage_q.b;
  assign sOut            = stage_q.s;
  assign immOut          = stage_q.imm;
  assign shiftOperandOut = stage_q.shift_operand;
  assign signedImm24Out  = stage_q.signed_imm24;
  assign destOut         = stage_q.dest;
  assign src1Out         = stage_q.src1;
  assign src2Out         = stage_q.src2;
  assign carryOut        = stage_q.carry;
  assign forwardEnOut    = stage_q.forward_en;
  assign validOut        = stage_q.valid;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Randomized and directed bench for id_ex_pipe_reg against a vector-level reference model.
module tb_id_ex_pipe_reg;
  localparam int VW = 156;

  logic        clkIn, rstIn, freezeIn, flushIn, hazardIn, forwardEnIn;
  logic [31:0] pcIn, val1In, valRmIn;
  logic [3:0]  exeCmdIn;
  logic        memREnIn, memWEnIn, wbEnIn, bIn, sIn, immIn, carryIn;
  logic [11:0] shiftOperandIn;
  logic [23:0] signedImm24In;
  logic [3:0]  destIn, src1In, src2In;

  logic [31:0] pcOut, val1Out, valRmOut;
  logic [3:0]  exeCmdOut;
  logic        memREnOut, memWEnOut, wbEnOut, bOut, sOut, immOut, carryOut, forwardEnOut, validOut;
  logic [11:0] shiftOperandOut;
  logic [23:0] signedImm24Out;
  logic [3:0]  destOut, src1Out, src2Out;

  id_ex_pipe_reg #(.DATA_W(32), .REG_ADDR_W(4)) dut (
    .clkIn(clkIn), .rstIn(rstIn), .freezeIn(freezeIn), .flushIn(flushIn), .hazardIn(hazardIn),
    .forwardEnIn(forwardEnIn), .pcIn(pcIn), .val1In(val1In), .valRmIn(valRmIn),
    .exeCmdIn(exeCmdIn), .memREnIn(memREnIn), .memWEnIn(memWEnIn), .wbEnIn(wbEnIn),
    .bIn(bIn), .sIn(sIn), .immIn(immIn), .shiftOperandIn(shiftOperandIn),
    .signedImm24In(signedImm24In), .destIn(destIn), .src1In(src1In), .src2In(src2In),
    .carryIn(carryIn),
    .pcOut(pcOut), .val1Out(val1Out), .valRmOut(valRmOut), .exeCmdOut(exeCmdOut),
    .memREnOut(memREnOut), .memWEnOut(memWEnOut), .wbEnOut(wbEnOut), .bOut(bOut),
    .sOut(sOut), .immOut(immOut), .shiftOperandOut(shiftOperandOut),
    .signedImm24Out(signedImm24Out), .destOut(destOut), .src1Out(src1Out),
    .src2Out(src2Out), .carryOut(carryOut), .forwardEnOut(forwardEnOut), .validOut(validOut)
  );

  logic [VW-1:0] in_vec, out_vec, exp_vec, saved_vec;
  logic          exp_valid;
  int            n_vec, n_err;

  assign in_vec  = {pcIn, val1In, valRmIn, exeCmdIn, memREnIn, memWEnIn, wbEnIn, bIn, sIn, immIn,
                    shiftOperandIn, signedImm24In, destIn, src1In, src2In, carryIn, forwardEnIn};
  assign out_vec = {pcOut, val1Out, valRmOut, exeCmdOut, memREnOut, memWEnOut, wbEnOut, bOut, sOut,
                    immOut, shiftOperandOut, signedImm24Out, destOut, src1Out, src2Out, carryOut,
                    forwardEnOut};

  initial begin
    clkIn = 1'b0;
    forever #5 clkIn = ~clkIn;
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_data();
    logic [31:0] r;
    pcIn = $urandom; val1In = $urandom; valRmIn = $urandom;
    r = $urandom;
    exeCmdIn = r[3:0]; memREnIn = r[4]; memWEnIn = r[5]; wbEnIn = r[6]; bIn = r[7];
    sIn = r[8]; immIn = r[9]; carryIn = r[10]; forwardEnIn = r[11];
    destIn = r[15:12]; src1In = r[19:16]; src2In = r[23:20];
    r = $urandom;
    shiftOperandIn = r[11:0];
    signedImm24In = r[31:8];
  endtask

  // Expected contents after a rising edge, straight from the priority rules.
  task automatic model_edge();
    if (!rstIn || flushIn) begin
      exp_vec = '0; exp_valid = 1'b0;
    end else if (freezeIn) begin
      // contents held
    end else if (hazardIn) begin
      exp_vec = '0; exp_valid = 1'b0;
    end else begin
      exp_vec = in_vec; exp_valid = 1'b1;
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clkIn);
    #1;
    model_edge();
    check({tag, ".data"}, out_vec, exp_vec);
    check({tag, ".valid"}, {{(VW-1){1'b0}}, validOut}, {{(VW-1){1'b0}}, exp_valid});
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    exp_vec = '0; exp_valid = 1'b0;
    rstIn = 1'b0; freezeIn = 1'b0; flushIn = 1'b0; hazardIn = 1'b0;
    rand_data();

    // Reset is asynchronous: outputs must be zero before the first clock edge.
    #2;
    check("rst_pre_edge", out_vec, '0);
    check("rst_pre_edge_valid", {{(VW-1){1'b0}}, validOut}, '0);
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle("rst_held");
    end
    @(negedge clkIn);
    rstIn = 1'b1;

    // Directed normal load.
    rand_data();
    pcIn = 32'h14; val1In = 32'hA5; destIn = 4'd3; src1In = 4'd1; src2In = 4'd2; wbEnIn = 1'b1;
    cycle("load");
    check("load_pc", {124'd0, pcOut}, {124'd0, 32'h14});
    check("load_dest", {152'd0, destOut}, {152'd0, 4'd3});
    saved_vec = out_vec;

    // Freeze for three edges while inputs churn; contents must stay at the loaded values.
    freezeIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      hazardIn = i[0];
      cycle("freeze");
      check("freeze_hold", out_vec, saved_vec);
    end
    freezeIn = 1'b0; hazardIn = 1'b0;
    rand_data();
    cycle("unfreeze");

    // Hazard bubble zeros writeback, sources and forward enable.
    rand_data();
    hazardIn = 1'b1; wbEnIn = 1'b1; src1In = 4'd5; forwardEnIn = 1'b1;
    cycle("hazard");
    check("hazard_wb", {155'd0, wbEnOut}, '0);
    check("hazard_src1", {152'd0, src1Out}, '0);
    check("hazard_fwd", {155'd0, forwardEnOut}, '0);
    hazardIn = 1'b0;

    // Flush wins over freeze.
    rand_data();
    cycle("preflush");
    freezeIn = 1'b1; flushIn = 1'b1;
    rand_data();
    cycle("flush_freeze");
    check("flush_freeze_valid", {155'd0, validOut}, '0);
    flushIn = 1'b0;

    // Reset pulse during freeze clears immediately; nothing is held afterwards.
    freezeIn = 1'b0;
    rand_data();
    cycle("prereset");
    freezeIn = 1'b1;
    rand_data();
    cycle("freeze2");
    #2;
    rstIn = 1'b0;
    #1;
    exp_vec = '0; exp_valid = 1'b0;
    check("midfreeze_rst", out_vec, '0);
    check("midfreeze_rst_valid", {155'd0, validOut}, '0);
    @(negedge clkIn);
    rstIn = 1'b1;
    cycle("post_rst_frozen");
    freezeIn = 1'b0;
    rand_data();
    cycle("post_rst_load");

    // Random control mix.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      r = $urandom;
      flushIn  = (r[3:0] == 4'd0);
      freezeIn = (r[7:4] < 4'd4);
      hazardIn = (r[11:8] < 4'd3);
      rand_data();
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
